// File: rtl/clb_cfg_pkg.sv
// Shared constants and FSM state encoding for the CLB configuration loader.
package clb_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         PROG_W_DEFAULT = 17;
  localparam int         WORD_BYTES     = 3;
  localparam int         ASM_W          = 8 * WORD_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT,
    ST_ERR
  } state_t;

endpackage

// File: rtl/clb_cfg_assembler.sv
// Byte-to-word assembler: shift history, byte counter, pad check and running XOR.
module clb_cfg_assembler
  import clb_cfg_pkg::*;
#(
  parameter int PROG_W = PROG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              take,
  input  logic [7:0]        data,
  output logic              word_last,
  output logic              pad_err,
  output logic [PROG_W-1:0] prog_word,
  output logic [7:0]        acc
);

  // Only the two older bytes need storage; the third is the byte on the bus.
  logic [ASM_W-9:0] hist_q;
  logic [1:0]       byte_cnt;

  assign word_last = (byte_cnt == 2'(WORD_BYTES - 1));
  assign pad_err   = (byte_cnt == 2'd0) && (data[7:1] != 7'd0);
  assign prog_word = PROG_W'({hist_q, data});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q   <= '0;
      byte_cnt <= '0;
      acc      <= '0;
    end else if (clr) begin
      hist_q   <= '0;
      byte_cnt <= '0;
      acc      <= '0;
    end else if (take) begin
      hist_q   <= {hist_q[ASM_W-17:0], data};
      acc      <= acc ^ data;
      byte_cnt <= word_last ? 2'd0 : byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/clb_config_loader.sv
// Framed byte-stream loader: collects NUM_CLB prog words into shadow slots and
// commits them to prog_bus only after a matching XOR checksum.
//
// state  | meaning
// IDLE   | waiting for sync byte, other bytes dropped
// LOAD   | receiving 3-byte payload words into shadow slots
// CHECK  | waiting for checksum byte
// COMMIT | one cycle, shadow slots copied to prog_bus on exit
// ERR    | frame rejected, waiting for sync byte
module clb_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int NUM_CLB = 4,
  parameter int PROG_W  = PROG_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                cfg_data,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [NUM_CLB*PROG_W-1:0] prog_bus,
  output logic                      cfg_done,
  output logic                      cfg_err,
  output logic                      busy
);

  localparam int WCW = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;

  state_t            state, state_nxt;
  logic              rdy_q;
  logic [WCW-1:0]    word_cnt;
  logic [PROG_W-1:0] shadow [NUM_CLB];

  logic              accept;
  logic              asm_clr, asm_take, slot_we;
  logic              word_last, pad_err;
  logic [PROG_W-1:0] prog_word;
  logic [7:0]        acc;

  clb_cfg_assembler #(.PROG_W(PROG_W)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .take      (asm_take),
    .data      (cfg_data),
    .word_last (word_last),
    .pad_err   (pad_err),
    .prog_word (prog_word),
    .acc       (acc)
  );

  // rdy_q holds ready low through reset and until the first clock after it.
  assign cfg_ready = rdy_q && (state != ST_COMMIT);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_err   = (state == ST_ERR);
  assign busy      = (state == ST_LOAD) || (state == ST_CHECK);

  always_comb begin
    state_nxt = state;
    asm_clr   = 1'b0;
    asm_take  = 1'b0;
    slot_we   = 1'b0;
    case (state)
      ST_IDLE, ST_ERR: begin
        if (accept && cfg_data == SYNC_BYTE) begin
          state_nxt = ST_LOAD;
          asm_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (pad_err) begin
            state_nxt = ST_ERR;
          end else begin
            asm_take = 1'b1;
            if (word_last) begin
              slot_we = 1'b1;
              if (word_cnt == WCW'(NUM_CLB - 1)) state_nxt = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (accept) state_nxt = (cfg_data == acc) ? ST_COMMIT : ST_ERR;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rdy_q    <= 1'b0;
      word_cnt <= '0;
      cfg_done <= 1'b0;
      prog_bus <= '0;
      for (int i = 0; i < NUM_CLB; i++) shadow[i] <= '0;
    end else begin
      state    <= state_nxt;
      rdy_q    <= 1'b1;
      cfg_done <= (state == ST_COMMIT);
      if (asm_clr)      word_cnt <= '0;
      else if (slot_we) word_cnt <= word_cnt + 1'b1;
      if (slot_we) shadow[word_cnt] <= prog_word;
      if (state == ST_COMMIT) begin
        for (int i = 0; i < NUM_CLB; i++) prog_bus[i*PROG_W +: PROG_W] <= shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_clb_config_loader.sv
// Directed bench for clb_config_loader with NUM_CLB=2; expected commits go
// through a scoreboard queue and are popped when cfg_done pulses.
module tb_clb_config_loader;

  localparam int NUM_CLB = 2;
  localparam int PROG_W  = 17;
  localparam int BW      = NUM_CLB * PROG_W;

  localparam logic [63:0]   FA    = 64'hA5_00_12_34_01_FF_FF_27;
  localparam logic [63:0]   FBAD  = 64'hA5_00_12_34_01_FF_FF_28;
  localparam logic [63:0]   FD    = 64'hA5_00_A5_A5_00_00_01_01;
  localparam logic [BW-1:0] BUS_A = {17'h1FFFF, 17'h01234};
  localparam logic [BW-1:0] BUS_D = {17'h00001, 17'h0A5A5};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    cfg_data = 8'h00;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [BW-1:0] prog_bus;
  logic          cfg_done;
  logic          cfg_err;
  logic          busy;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int done_pulses = 0;
  logic [BW-1:0] sb [$];

  clb_config_loader #(.NUM_CLB(NUM_CLB), .PROG_W(PROG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .prog_bus  (prog_bus),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cfg_done === 1'b1) done_pulses <= done_pulses + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input logic gap);
    logic r;
    logic accepted;
    if (gap) begin
      cfg_valid = 1'b0;
      @(negedge clk);
    end
    cfg_data  = b;
    cfg_valid = 1'b1;
    accepted  = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) begin
      r = cfg_ready;
      @(negedge clk);
      if (r) accepted = 1'b1;
    end
    acc_cyc = cyc;
    check("accept_timeout", {63'd0, accepted}, 64'd1);
  endtask

  task automatic send_frame(input logic [63:0] f, input logic gap);
    for (int i = 7; i >= 0; i--) send(f[i*8 +: 8], gap);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic found;
    logic [BW-1:0] exp;
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      @(negedge clk);
      if (cfg_done === 1'b1) found = 1'b1;
    end
    check({tag, "_done_seen"}, {63'd0, found}, 64'd1);
    if (found) begin
      check({tag, "_sb_nonempty"}, {63'd0, (sb.size() != 0)}, 64'd1);
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      check({tag, "_prog_bus"}, 64'(prog_bus), 64'(exp));
      check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd1);
      check({tag, "_err_low"}, {63'd0, cfg_err}, 64'd0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, {63'd0, cfg_done}, 64'd0);
    end
  endtask

  initial begin
    // reset state
    @(negedge clk);
    check("rst_prog_bus", 64'(prog_bus), 64'd0);
    check("rst_ready", {63'd0, cfg_ready}, 64'd0);
    check("rst_done", {63'd0, cfg_done}, 64'd0);
    check("rst_err", {63'd0, cfg_err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    #1 check("ready_before_edge", {63'd0, cfg_ready}, 64'd0);
    @(negedge clk);
    check("ready_after_edge", {63'd0, cfg_ready}, 64'd1);

    // valid frame
    sb.push_back(BUS_A);
    send(8'hA5, 1'b0);
    check("a_busy_load", {63'd0, busy}, 64'd1);
    for (int i = 6; i >= 0; i--) send(FA[i*8 +: 8], 1'b0);
    cfg_valid = 1'b0;
    check("a_commit_ready", {63'd0, cfg_ready}, 64'd0);
    check("a_commit_busy", {63'd0, busy}, 64'd0);
    wait_done("a");

    // bad checksum leaves prog_bus alone
    send_frame(FBAD, 1'b0);
    @(negedge clk);
    check("bad_err", {63'd0, cfg_err}, 64'd1);
    check("bad_busy", {63'd0, busy}, 64'd0);
    check("bad_prog_bus", 64'(prog_bus), 64'(BUS_A));

    // recovery from ERR
    sb.push_back(BUS_A);
    send(8'hA5, 1'b0);
    check("rec_err_cleared", {63'd0, cfg_err}, 64'd0);
    check("rec_busy", {63'd0, busy}, 64'd1);
    for (int i = 6; i >= 0; i--) send(FA[i*8 +: 8], 1'b0);
    cfg_valid = 1'b0;
    wait_done("rec");

    // nonzero pad bits in first word byte
    send(8'hA5, 1'b0);
    send(8'h02, 1'b0);
    check("pad_err", {63'd0, cfg_err}, 64'd1);
    check("pad_busy", {63'd0, busy}, 64'd0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("pad_err_hold", {63'd0, cfg_err}, 64'd1);

    // junk byte then stalled frame
    send(8'h11, 1'b0);
    check("junk_dropped", {63'd0, busy}, 64'd0);
    sb.push_back(BUS_A);
    send_frame(FA, 1'b1);
    wait_done("gap");

    // reset mid-frame
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    send(8'h12, 1'b0);
    check("mid_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_prog_bus", 64'(prog_bus), 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_ready", {63'd0, cfg_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 4; i >= 0; i--) send(FA[i*8 +: 8], 1'b0);
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("stale_busy", {63'd0, busy}, 64'd0);
    check("stale_prog_bus", 64'(prog_bus), 64'd0);
    check("stale_pulses", 64'(done_pulses), 64'd3);

    // A5 bytes inside the payload are data
    sb.push_back(BUS_D);
    send_frame(FD, 1'b0);
    wait_done("a5data");

    sb.push_back(BUS_A);
    send_frame(FA, 1'b0);
    wait_done("last");

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("done_pulses", 64'(done_pulses), 64'd5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
